mul_iter: RTL and testbench
===========================

Name: mul_iter

Overview:
Parametrised iterative shift-add multiplier. It supports all four signed/unsigned operand combinations, so it covers RISC-V MUL/MULH/MULHSU/MULHU.
- Input side: valid/ready. Output side: valid/ready with backpressure.
- Synchronous flush for pipeline kill.
- Sits in the EXU as the long-latency multiply unit, next to the ALU.
- Retires one multiplier bit per cycle; 2W-bit product.

Parameters:
W, 64, operand width in bits (W >= 4).
CNT_W, $clog2(W+1), iteration counter width (derived, not overridden).

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  operands valid
in_ready  out  1  unit can accept; combinational, high only in IDLE
mode  in  2  {a_signed, b_signed}: 00 uu, 01 us, 10 su, 11 ss
multiplicand  in  W  operand a
multiplier  in  W  operand b
flush  in  1  abort current operation, discard result
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result_h  out  W  product[2W-1:W]
result_l  out  W  product[W-1:0]

Behaviour:
- States: IDLE, BUSY, FIX, DONE.
- Reset values: state IDLE, out_valid 0, result_h/result_l 0, counter 0. in_ready is 1 after reset.
- Accept: when in_valid && in_ready at an edge, register the following and go to BUSY with cnt=0:
  - |a| and |b| (two's-complement negate if the operand is flagged signed and its MSB is 1);
  - neg = (a negative) XOR (b negative);
  - accumulator cleared.
- BUSY: each edge, if b_r[0] then acc[2W-1:W] += a_r (carry kept in a W+1-bit sum); then shift {carry, acc} and b_r right by 1; cnt++. After W iterations (cnt==W-1 at the edge), go to FIX.
- FIX: if neg, acc <= ~acc + 1 (2W-bit). Go to DONE.
- DONE: out_valid=1; result_h/l = acc, held stable until out_ready. On out_valid && out_ready, go to IDLE next edge. There is no same-cycle re-accept: in_ready=0 in DONE.
- Latency: accept edge t0 → out_valid visible after edge t0+W+1 (65 cycles for W=64).
- Width rules:
  - Magnitudes are unsigned W-bit; min-negative magnitude 2^(W-1) fits.
  - The magnitude product is < 2^(2W), so there is no overflow.
  - The final negate wraps modulo 2^(2W).
- Flush: highest priority in every state; the next state is IDLE and out_valid drops next cycle. A flush coincident with an accept discards that accept. A flush in DONE with out_ready also set counts as flush only (the result is not consumed).
- Reset mid-operation: identical to power-on reset; all state is cleared.
- Inputs are ignored outside IDLE. Operand/mode changes during BUSY have no effect.
- Result registers keep the last value after the DONE→IDLE handshake (outputs are don't-care while out_valid=0).

Optional Feature:
MUL_EARLY_EXIT_EN
- Defined: in BUSY, if the remaining b_r bits are all zero, perform a single final alignment shift (acc >> remaining count) and go to FIX immediately. Latency becomes 2..W+1 cycles; results are bit-identical. Example: b=0 gives out_valid 2 cycles after accept.
- Undefined: fixed W+1 latency, no zero-detect logic.

Decomposition:
- Package mul_pkg:
  - mode encoding constants (MUL_UU=2'b00, MUL_US=2'b01, MUL_SU=2'b10, MUL_SS=2'b11);
  - state enum typedef mul_state_t {IDLE, BUSY, FIX, DONE}.
- Single module; no sub-module. The magnitude/negate helper is a function in mul_pkg, reused in FIX.

Test Plan:
1. W=64, uu, a=3, b=5 → result_h=0, result_l=15; out_valid exactly 65 cycles after accept; in_ready=0 throughout.
2. Sign modes:
   - ss: a=-1, b=-1 → h=0, l=1.
   - ss: a=b=0x8000_0000_0000_0000 → h=0x4000_0000_0000_0000, l=0.
   - su: a=-1, b=0xFFFF_FFFF_FFFF_FFFF → h=0xFFFF_FFFF_FFFF_FFFF, l=1.
3. uu max×max: a=b=0xFFFF_FFFF_FFFF_FFFF → h=0xFFFF_FFFF_FFFF_FFFE, l=1.
4. Backpressure: out_ready held low 10 cycles after out_valid → result stable, out_valid held, in_ready=0. out_ready=1 → next cycle in_ready=1; the next op accepted one cycle later returns correctly.
5. Flush:
   - at iteration 20 → next cycle state IDLE, in_ready=1, no out_valid ever; a following op (uu 7×9) returns 63.
   - flush with in_valid in IDLE → not accepted.
6. Reset mid-BUSY: rst_n low one cycle at iteration 30 → out_valid=0, result 0, in_ready=1. With MUL_EARLY_EXIT_EN: uu a=5, b=1 → result 5 after 2 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: the operand-mode encoding,
// the FSM state type and the conditional two's-complement helper.
package mul_pkg;

  // mode = {a_signed, b_signed}
  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_US = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_SS = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} mul_state_t;

  // Helper operates on a fixed wide vector; callers zero-extend and slice.
  // 128 bits covers the 2W-bit product negate for W up to 64.
  localparam int MUL_FN_W = 128;

  function automatic logic [MUL_FN_W-1:0] cond_neg(input logic [MUL_FN_W-1:0] x,
                                                   input logic                en);
    return en ? (~x + MUL_FN_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, 2W-bit product.
// Operands are converted to magnitudes on accept; the sign is reapplied in FIX.
// Optional build macro MUL_EARLY_EXIT_EN: finish BUSY as soon as the remaining
// multiplier bits are all zero (results unchanged, shorter latency).
module mul_iter
  import mul_pkg::*;
#(
  parameter  int W     = 64,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [W-1:0] multiplicand,
  input  logic [W-1:0] multiplier,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result_h,
  output logic [W-1:0] result_l
);

  mul_state_t       state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic                accept;
  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [MUL_FN_W-1:0] a_fn, b_fn, acc_fn;
  logic                unused_fn;
  logic [W:0]          sum;
  logic [2*W-1:0]      acc_step;
  logic                last;
  logic                finish;

  assign accept = in_valid && (state_q == IDLE) && !flush;

  assign a_sgn = (mode == MUL_SU) || (mode == MUL_SS);
  assign b_sgn = (mode == MUL_US) || (mode == MUL_SS);
  assign a_neg = a_sgn && multiplicand[W-1];
  assign b_neg = b_sgn && multiplier[W-1];

  assign a_fn   = cond_neg(MUL_FN_W'(multiplicand), a_neg);
  assign b_fn   = cond_neg(MUL_FN_W'(multiplier), b_neg);
  assign acc_fn = cond_neg(MUL_FN_W'(acc_q), neg_q);
  // Upper helper bits beyond the working width are intentionally dropped.
  assign unused_fn = ^{a_fn, b_fn, acc_fn};

  // One shift-add step: conditional add into the high half, then shift the
  // (W+1)-bit sum together with the low half right by one.
  assign sum      = {1'b0, acc_q[2*W-1:W]} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign acc_step = {sum, acc_q[W-1:1]};
  assign last     = (cnt_q == CNT_W'(W - 1));

`ifdef MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0] rem;
  logic             zero_rest;
  assign rem       = CNT_W'(W - 1) - cnt_q;
  assign zero_rest = (b_q[W-1:1] == '0);
  assign finish    = last || zero_rest;
`else
  assign finish    = last;
`endif

  // State register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (in_valid)  state_d = BUSY;
        BUSY:    if (finish)    state_d = FIX;
        FIX:                    state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values: load magnitudes, iterate, apply sign.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    if (!flush) begin
      unique case (state_q)
        IDLE: if (accept) begin
          a_d   = a_fn[W-1:0];
          b_d   = b_fn[W-1:0];
          neg_d = a_neg ^ b_neg;
          acc_d = '0;
          cnt_d = '0;
        end
        BUSY: begin
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
          // Remaining multiplier bits are zero: align in one go.
          acc_d = zero_rest ? (acc_step >> rem) : acc_step;
`else
          acc_d = acc_step;
`endif
        end
        FIX:     acc_d = acc_fn[2*W-1:0];
        default: ;
      endcase
    end
  end

  // Datapath registers; reset clears everything, result included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
    end
  end

  assign result_h = acc_q[2*W-1:W];
  assign result_l = acc_q[W-1:0];

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: expected products go into a scoreboard queue
// when an operation is issued and are popped when out_valid appears.
module tb_mul_iter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] rh, rl;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] sb[$];

  mul_iter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .multiplicand(a), .multiplier(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_h(rh), .result_l(rl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product: sign/zero-extend to 2W and multiply modulo 2^(2W).
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] m);
    logic [2*W-1:0] xe, ye;
    xe = m[1] ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
    ye = m[0] ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
    return xe * ye;
  endfunction

  // Cycles from accept edge to out_valid.
  function automatic int model_lat(input logic [W-1:0] y, input logic [1:0] m);
`ifdef MUL_EARLY_EXIT_EN
    logic [W-1:0] ym;
    int k;
    ym = (m[0] && y[W-1]) ? -y : y;
    k = 0;
    for (int i = 0; i < W; i++) if (ym[i]) k = i;
    return k + 2;
`else
    return W + 1 + 0 * int'(y[0] ^ m[0]);
`endif
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m);
    @(negedge clk);
    chk("in_ready_before_op", {127'b0, in_ready}, 1);
    a = x; b = y; mode = m; in_valid = 1'b1;
    sb.push_back(model(x, y, m));
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x; b = ~y; mode = ~m;  // must be ignored while busy
  endtask

  task automatic finish_op(input string tag, input int exp_lat, input int hold);
    int cyc;
    bit rdy_seen;
    logic [2*W-1:0] exp;
    cyc = 0;
    rdy_seen = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) rdy_seen = 1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, {127'b0, out_valid}, 1);
    chk({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
    chk({tag, "_busy_rdy"}, {127'b0, rdy_seen}, 0);
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_res"}, {rh, rl}, exp);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold_res"}, {rh, rl}, exp);
      chk({tag, "_hold_valid"}, {127'b0, out_valid}, 1);
      chk({tag, "_hold_rdy"}, {127'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_rdy"}, {127'b0, in_ready}, 1);
    chk({tag, "_post_valid"}, {127'b0, out_valid}, 0);
  endtask

  task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [1:0] m, input int hold);
    start_op(x, y, m);
    finish_op(tag, model_lat(y, m), hold);
  endtask

  task automatic watch_no_valid(input string tag, input int ncyc);
    bit seen;
    seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk(tag, {127'b0, seen}, 0);
  endtask

  initial begin
    logic [W-1:0] mn, ones;
    mn   = {1'b1, {(W-1){1'b0}}};
    ones = '1;

    // reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", {127'b0, in_ready}, 1);
    chk("rst_out_valid", {127'b0, out_valid}, 0);
    chk("rst_result", {rh, rl}, 0);

    // basic and sign-mode products
    run("uu_3x5",    64'd3, 64'd5, 2'b00, 0);
    run("ss_m1xm1",  ones,  ones,  2'b11, 0);
    run("ss_minmin", mn,    mn,    2'b11, 0);
    run("su_m1xmax", ones,  ones,  2'b10, 0);
    run("uu_maxmax", ones,  ones,  2'b00, 0);
    run("us_7xm2",   64'd7, -64'd2, 2'b01, 0);
    run("ss_0xm5",   64'd0, -64'd5, 2'b11, 0);

    // backpressure, then an immediate follow-on op
    run("bp_hold", 64'h1234_5678_9abc_def0, 64'hfedc_ba98_7654_3210, 2'b11, 10);
    run("bp_next", 64'd11, 64'd13, 2'b00, 0);

    // flush at iteration 20
    start_op(64'd100, 64'd200, 2'b00);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    void'(sb.pop_back());
    chk("flush_in_ready", {127'b0, in_ready}, 1);
    chk("flush_out_valid", {127'b0, out_valid}, 0);
    watch_no_valid("flush_no_result", 70);
    run("flush_after_7x9", 64'd7, 64'd9, 2'b00, 0);

    // flush together with in_valid in IDLE: no accept
    @(negedge clk);
    a = 64'd4; b = 64'd4; mode = 2'b00;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_rdy", {127'b0, in_ready}, 1);
    watch_no_valid("flush_idle_no_result", 70);

    // reset in the middle of BUSY
    start_op(64'd123, 64'd456, 2'b00);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    chk("midrst_out_valid", {127'b0, out_valid}, 0);
    chk("midrst_result", {rh, rl}, 0);
    chk("midrst_in_ready", {127'b0, in_ready}, 1);
    watch_no_valid("midrst_no_result", 70);

    // short multipliers (early-exit latencies when enabled)
    run("uu_5x1", 64'd5, 64'd1, 2'b00, 0);
    run("uu_9x0", 64'd9, 64'd0, 2'b00, 0);
    run("ss_m3xm1", -64'd3, ones, 2'b11, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
